// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between NUM_REQ
// writeback requesters (ALU, load unit, CSR/misc) using valid/ready handshakes.
// One grant per cycle; the winning write is registered and driven one cycle later.
// Writes to x0 complete the handshake but are dropped and counted in drop_cnt.
// Optional feature macro: RR_ARB_EN selects round-robin arbitration; when it is
// undefined the arbiter is fixed priority (lowest index wins) with no pointer.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rg_wrt_en,
  output logic [ADDR_W-1:0]         rg_wrt_addr,
  output logic [DATA_W-1:0]         rg_wrt_data,
  output logic [15:0]               drop_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [15:0]        drop_q,    drop_d;

`ifdef RR_ARB_EN
  logic [PTR_W-1:0]   ptr_q, ptr_d;
`endif

  // Arbitration: pick one valid requester unless held in reset or stalled.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (reset && !wb_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RR_ARB_EN
        idx = (int'(ptr_q) + k) % NUM_REQ;
`else
        idx = k;
`endif
        if (!gnt_any && req_valid[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = PTR_W'(idx);
        end
      end
    end
  end

  assign req_ready = gnt;
  assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];

  // Next-state for the write slot and the x0 drop counter; addr/data hold when idle.
  always_comb begin
    wr_en_d   = gnt_any && (sel_addr != '0);
    wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data : wr_data_q;
    drop_d    = drop_q;
    if (gnt_any && (sel_addr == '0) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Write slot and drop counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

`ifdef RR_ARB_EN
  // Pointer advances past the winner only on cycles that actually grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign rg_wrt_en   = wr_en_q;
  assign rg_wrt_addr = wr_addr_q;
  assign rg_wrt_data = wr_data_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (3 requesters, 5-bit addr, 32-bit data).
// Expectations follow the RR_ARB_EN setting of the build.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stall;
  logic [2:0]  req_valid;
  logic [4:0]  a0, a1, a2;
  logic [31:0] d0, d1, d2;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  assign req_addr = {a2, a1, a0};
  assign req_data = {d2, d1, d0};

  rf_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_stall   (wb_stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rg_wrt_en  (rg_wrt_en),
    .rg_wrt_addr(rg_wrt_addr),
    .rg_wrt_data(rg_wrt_data),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  exp_gnt [6];
  logic [4:0]  exp_addr[6];
  logic [31:0] exp_data[6];

  initial begin
    reset = 1'b0; wb_stall = 1'b0; req_valid = 3'b111;
    a0 = 5'd1; a1 = 5'd2; a2 = 5'd3;
    d0 = 32'hA000_0001; d1 = 32'hB000_0002; d2 = 32'hC000_0003;

    // Reset held two cycles with all requesters valid.
    #1;
    chk("rst_ready0", 64'(req_ready), 64'd0);
    tick();
    chk("rst_ready1", 64'(req_ready), 64'd0);
    chk("rst_en1",    64'(rg_wrt_en), 64'd0);
    chk("rst_drop1",  64'(drop_cnt),  64'd0);
    chk("rst_addr1",  64'(rg_wrt_addr), 64'd0);
    tick();
    chk("rst_ready2", 64'(req_ready), 64'd0);
    chk("rst_en2",    64'(rg_wrt_en), 64'd0);
    chk("rst_data2",  64'(rg_wrt_data), 64'd0);

    // Contention: all three valid for six cycles.
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef RR_ARB_EN
      exp_gnt[i] = 3'b001 << (i % 3);
      exp_addr[i] = 5'(1 + (i % 3));
      exp_data[i] = (i % 3 == 0) ? 32'hA000_0001 : (i % 3 == 1) ? 32'hB000_0002 : 32'hC000_0003;
`else
      exp_gnt[i] = 3'b001;
      exp_addr[i] = 5'd1;
      exp_data[i] = 32'hA000_0001;
`endif
    end
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cont_ready%0d", i), 64'(req_ready), 64'(exp_gnt[i]));
      tick();
      chk($sformatf("cont_en%0d", i),   64'(rg_wrt_en),   64'd1);
      chk($sformatf("cont_addr%0d", i), 64'(rg_wrt_addr), 64'(exp_addr[i]));
      chk($sformatf("cont_data%0d", i), 64'(rg_wrt_data), 64'(exp_data[i]));
    end

    // Idle: no valid requests.
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle_en",   64'(rg_wrt_en),   64'd0);
    chk("idle_addr", 64'(rg_wrt_addr), 64'(exp_addr[5]));

    // Single write from requester 1.
    req_valid = 3'b010; a1 = 5'd5; d1 = 32'hDEAD_BEEF;
    #1;
    chk("single_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    chk("single_en",   64'(rg_wrt_en),   64'd1);
    chk("single_addr", 64'(rg_wrt_addr), 64'd5);
    chk("single_data", 64'(rg_wrt_data), 64'hDEAD_BEEF);
    tick();
    chk("single_en_n2",   64'(rg_wrt_en),   64'd0);
    chk("single_data_n2", 64'(rg_wrt_data), 64'hDEAD_BEEF);

    // x0 drop from requester 0.
    req_valid = 3'b001; a0 = 5'd0; d0 = 32'h1234_5678;
    #1;
    chk("x0_ready", 64'(req_ready), 64'b001);
    chk("x0_drop_before", 64'(drop_cnt), 64'd0);
    tick();
    chk("x0_en",   64'(rg_wrt_en), 64'd0);
    chk("x0_drop", 64'(drop_cnt),  64'd1);

    // Stall two cycles with all valid, then release.
    a0 = 5'd1; d0 = 32'hA000_0001; a1 = 5'd2; d1 = 32'hB000_0002;
    req_valid = 3'b111; wb_stall = 1'b1;
    #1;
    chk("stall_ready0", 64'(req_ready), 64'd0);
    tick();
    chk("stall_en0",    64'(rg_wrt_en), 64'd0);
    chk("stall_ready1", 64'(req_ready), 64'd0);
    tick();
    chk("stall_en1",    64'(rg_wrt_en), 64'd0);
    wb_stall = 1'b0;
    #1;
`ifdef RR_ARB_EN
    chk("post_stall_ready", 64'(req_ready), 64'b010);
    tick();
    chk("post_stall_addr", 64'(rg_wrt_addr), 64'd2);
`else
    chk("post_stall_ready", 64'(req_ready), 64'b001);
    tick();
    chk("post_stall_addr", 64'(rg_wrt_addr), 64'd1);
`endif
    chk("post_stall_en", 64'(rg_wrt_en), 64'd1);

    // Reset mid-operation: requester 2 granted, reset lands on the closing edge.
    req_valid = 3'b100; a2 = 5'd7; d2 = 32'h7777_7777;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'b100);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("midrst_en",   64'(rg_wrt_en),   64'd0);
    chk("midrst_addr", 64'(rg_wrt_addr), 64'd0);
    chk("midrst_drop", 64'(drop_cnt),    64'd0);
    reset = 1'b1; req_valid = 3'b111;
    #1;
    chk("midrst_ptr_ready", 64'(req_ready), 64'b001);
    tick();
    chk("midrst_after_addr", 64'(rg_wrt_addr), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
